// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end: decodes MIPS-style memory ops, drives an
// address/data handshake memory port and returns a registered response.
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt_old,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] OpLb  = 4'b0000;
    localparam logic [3:0] OpLbu = 4'b0001;
    localparam logic [3:0] OpLh  = 4'b0010;
    localparam logic [3:0] OpLhu = 4'b0011;
    localparam logic [3:0] OpLw  = 4'b0100;
    localparam logic [3:0] OpLwl = 4'b0101;
    localparam logic [3:0] OpLwr = 4'b0110;
    localparam logic [3:0] OpSb  = 4'b1000;
    localparam logic [3:0] OpSh  = 4'b1001;
    localparam logic [3:0] OpSw  = 4'b1010;
    localparam logic [3:0] OpSwl = 4'b1011;
    localparam logic [3:0] OpSwr = 4'b1100;

    localparam bit          TimeoutEn  = (TIMEOUT_CYC != 0);
    localparam logic [16:0] TimeoutVal = 17'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic [1:0]        r_resp_err;
    logic              r_mem_req;
    logic              r_mem_wr;
    logic [3:0]        r_mem_wstrb;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_op;
    logic [1:0]        r_off;
    logic [31:0]       r_rt_old;
    logic [15:0]       r_cnt;

    logic [1:0]  w_off;
    logic [4:0]  w_shamt;
    logic        w_legal;
    logic        w_misal;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_strb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [16:0] w_cnt_inc;
    logic        w_timeout;

    // Request decode: legality, alignment and lane-aligned store data/strobes.
    always_comb begin
        w_off     = req_addr[1:0];
        w_shamt   = {w_off, 3'b000};
        w_legal   = 1'b1;
        w_misal   = 1'b0;
        w_st_data = 32'h0;
        w_st_strb = 4'b0000;
        case (req_op)
            OpLb, OpLbu, OpLwl, OpLwr: ;
            OpLh, OpLhu: w_misal = req_addr[0];
            OpLw:        w_misal = |req_addr[1:0];
            OpSb: begin
                w_st_data = {4{req_wdata[7:0]}};
                w_st_strb = 4'b0001 << w_off;
            end
            OpSh: begin
                w_misal   = req_addr[0];
                w_st_data = {2{req_wdata[15:0]}};
                w_st_strb = w_off[1] ? 4'b1100 : 4'b0011;
            end
            OpSw: begin
                w_misal   = |req_addr[1:0];
                w_st_data = req_wdata;
                w_st_strb = 4'b1111;
            end
            OpSwl: begin
                // 3 - off == ~off for a 2-bit offset
                w_st_data = req_wdata >> {~w_off, 3'b000};
                w_st_strb = 4'b1111 >> ~w_off;
            end
            OpSwr: begin
                w_st_data = req_wdata << w_shamt;
                w_st_strb = 4'b1111 << w_off;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Load result formation from the returned word and the latched request.
    always_comb begin
        w_byte = mem_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load = 32'h0;
        case (r_op)
            OpLb:  w_load = {{24{w_byte[7]}}, w_byte};
            OpLbu: w_load = {24'h0, w_byte};
            OpLh:  w_load = {{16{w_half[15]}}, w_half};
            OpLhu: w_load = {16'h0, w_half};
            OpLw:  w_load = mem_rdata;
            OpLwl: begin
                case (r_off)
                    2'd0:    w_load = {mem_rdata[7:0], r_rt_old[23:0]};
                    2'd1:    w_load = {mem_rdata[15:0], r_rt_old[15:0]};
                    2'd2:    w_load = {mem_rdata[23:0], r_rt_old[7:0]};
                    default: w_load = mem_rdata;
                endcase
            end
            OpLwr: begin
                case (r_off)
                    2'd0:    w_load = mem_rdata;
                    2'd1:    w_load = {r_rt_old[31:24], mem_rdata[31:8]};
                    2'd2:    w_load = {r_rt_old[31:16], mem_rdata[31:16]};
                    default: w_load = {r_rt_old[31:8], mem_rdata[31:24]};
                endcase
            end
            default: w_load = 32'h0;
        endcase
    end

    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_timeout = TimeoutEn && (w_cnt_inc == TimeoutVal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 2'b00;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wstrb  <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
            r_op         <= 4'h0;
            r_off        <= 2'b00;
            r_rt_old     <= 32'h0;
            r_cnt        <= 16'h0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op        <= req_op;
                        r_off       <= w_off;
                        r_rt_old    <= req_rt_old;
                        r_cnt       <= 16'h0;
                        if (!w_legal || w_misal) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= w_legal ? 2'b01 : 2'b11;
                            r_resp_rdata <= 32'h0;
                            r_state      <= StResp;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_wr    <= req_op[3];
                            r_mem_wstrb <= w_st_strb;
                            r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_mem_wdata <= w_st_data;
                            r_state     <= StAddr;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                StAddr: begin
                    // An address accept on the timeout cycle still wins.
                    if (mem_addr_ok) begin
                        r_mem_req <= 1'b0;
                        r_state   <= StData;
                    end else if (w_timeout) begin
                        r_mem_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 2'b10;
                        r_resp_rdata <= 32'h0;
                        r_state      <= StResp;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end
                StData: begin
                    if (mem_data_ok) begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 2'b00;
                        r_resp_rdata <= w_load;
                        r_state      <= StResp;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_req    = r_mem_req;
    assign mem_wr     = r_mem_wr;
    assign mem_wstrb  = r_mem_wstrb;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: acts as requester and memory, and
// compares every transaction against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   req_rt_old;
    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_rdata;
    logic [1:0]    resp_err;
    logic          mem_req;
    logic          mem_wr;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(
        .ADDR_W     (AW),
        .TIMEOUT_CYC(TO)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rt_old (req_rt_old),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .mem_wstrb  (mem_wstrb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    function automatic bit m_legal(input logic [3:0] op);
        return (op <= 4'd6) || (op >= 4'd8 && op <= 4'd12);
    endfunction

    function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd2 || op == 4'd3 || op == 4'd9) return a[0];
        if (op == 4'd4 || op == 4'd10) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [3:0] op, input int o);
        case (op)
            4'd8:    return 4'(1 << o);
            4'd9:    return (o == 0) ? 4'd3 : 4'd12;
            4'd10:   return 4'd15;
            4'd11:   return 4'((1 << (o + 1)) - 1);
            4'd12:   return 4'((15 << o) & 15);
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd,
                                            input int o);
        case (op)
            4'd8:    return (wd & 32'hFF) * 32'h0101_0101;
            4'd9:    return (wd & 32'hFFFF) * 32'h0001_0001;
            4'd10:   return wd;
            4'd11:   return wd >> (8 * (3 - o));
            4'd12:   return wd << (8 * o);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input int o,
                                           input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(rd >> (8 * o));
        h = 16'(rd >> (8 * o));
        r = rt;
        case (op)
            4'd0: r = 32'($signed(b));
            4'd1: r = 32'(b);
            4'd2: r = 32'($signed(h));
            4'd3: r = 32'(h);
            4'd4: r = rd;
            4'd5: for (int i = 0; i < 4; i++)
                if (i >= 3 - o) r[8*i +: 8] = rd[8*(i - (3 - o)) +: 8];
            4'd6: for (int i = 0; i < 4; i++)
                if (i <= 3 - o) r[8*i +: 8] = rd[8*(i + o) +: 8];
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // ---- one full transaction, memory latencies given in cycles ----
    task automatic do_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rt, input logic [31:0] rd,
                          input int alat, input int dlat, input int rlat);
        int          o;
        int          n;
        bit          timed_out;
        bit          chk_rd;
        logic [1:0]  eerr;
        logic [31:0] erd;
        o      = int'(addr[1:0]);
        n      = 0;
        chk_rd = 1'b1;
        erd    = 32'h0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        req_rt_old = rt;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_op     = 4'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rt_old = $urandom;
        check("req_ready_busy", 32'(req_ready), 32'd0);
        if (!m_legal(op) || m_misal(op, addr)) begin
            eerr   = m_legal(op) ? 2'b01 : 2'b11;
            chk_rd = 1'b0;
            check("err_no_mem_req", 32'(mem_req), 32'd0);
        end else begin
            timed_out = 1'b0;
            for (int c = 0; c < 64; c++) begin
                check("mem_req", 32'(mem_req), 32'd1);
                check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("mem_wr", 32'(mem_wr), 32'(op[3]));
                check("mem_wstrb", 32'(mem_wstrb), 32'(m_strb(op, o)));
                if (op[3]) check("mem_wdata", mem_wdata, m_wdata(op, wd, o));
                mem_addr_ok = (c == alat);
                mem_data_ok = 1'($urandom);
                mem_rdata   = $urandom;
                @(posedge clk); #1;
                mem_addr_ok = 1'b0;
                mem_data_ok = 1'b0;
                if (c == alat) break;
                if (c + 1 == int'(TO)) begin
                    timed_out = 1'b1;
                    break;
                end
            end
            check("mem_req_drop", 32'(mem_req), 32'd0);
            if (timed_out) begin
                eerr   = 2'b10;
                chk_rd = 1'b0;
            end else begin
                for (int d = 0; d < dlat; d++) begin
                    mem_rdata = $urandom;
                    @(posedge clk); #1;
                    check("data_wait", 32'(resp_valid), 32'd0);
                end
                mem_data_ok = 1'b1;
                mem_rdata   = rd;
                @(posedge clk); #1;
                mem_data_ok = 1'b0;
                mem_rdata   = $urandom;
                eerr        = 2'b00;
                erd         = op[3] ? 32'h0 : m_load(op, o, rd, rt);
            end
        end
        for (int r = 0; r <= rlat; r++) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_err", 32'(resp_err), 32'(eerr));
            if (chk_rd) check("resp_rdata", resp_rdata, erd);
            check("resp_no_mem_req", 32'(mem_req), 32'd0);
            if (r == rlat) resp_ready = 1'b1;
            mem_addr_ok = 1'($urandom);
            mem_data_ok = 1'($urandom);
            @(posedge clk); #1;
            resp_ready  = 1'b0;
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
        end
        check("resp_done", 32'(resp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_op      = 4'h0;
        req_addr    = '0;
        req_wdata   = 32'h0;
        req_rt_old  = 32'h0;
        resp_ready  = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Directed cases
        do_txn(4'b0000, 32'h1003, 32'h0, 32'h0, 32'h80FF_1234, 1, 1, 0);
        do_txn(4'b1011, 32'h2001, 32'hAABB_CCDD, 32'h0, 32'h0, 0, 0, 0);
        do_txn(4'b1100, 32'h2001, 32'hAABB_CCDD, 32'h0, 32'h0, 2, 0, 1);
        do_txn(4'b0110, 32'h12, 32'h0, 32'h1122_3344, 32'hA1B2_C3D4, 0, 2, 0);
        do_txn(4'b0100, 32'h6, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        do_txn(4'b0111, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        do_txn(4'b0101, 32'h41, 32'h0, 32'h5566_7788, 32'hDEAD_BEEF, 10, 0, 3);
        do_txn(4'b1001, 32'h22, 32'h1234_5678, 32'h0, 32'h0, 3, 1, 0);

        // Reset while waiting for data; late data ack must be ignored
        n_checks = n_checks;
        req_valid = 1'b1;
        req_op    = 4'b0100;
        req_addr  = 32'h100;
        @(posedge clk); #1;
        req_valid   = 1'b0;
        mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        check("pre_rst_in_data", 32'(mem_req), 32'd0);
        reset = 1'b1;
        #2;
        check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_data_ok = 1'b0;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("late_data_no_resp", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            do_txn(op, a, $urandom, $urandom, $urandom, $urandom_range(0, 5),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address width (>=3). TIMEOUT_CYC, 16, address-phase timeout in cycles (0 = disabled, max 65535).
REQ-002 SHALL use one clock; reset is asynchronous and active-high. Ports are clk and reset.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- req_op  in  4  opcode.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data (rt).
- req_rt_old  in  32  old rt value, used for the LWL/LWR merge.
- resp_valid  out  1  response held.
- resp_ready  in  1  response consumed.
- resp_rdata  out  32  load result.
- resp_err  out  2  00 ok, 01 address error, 10 timeout, 11 illegal op.
- mem_req  out  1  memory request.
- mem_wr  out  1  write.
- mem_wstrb  out  4  byte strobes.
- mem_addr  out  ADDR_W  word address, bits [1:0] = 0.
- mem_wdata  out  32  lane-aligned data.
- mem_addr_ok  in  1  address accepted.
- mem_data_ok  in  1  data or write ack.
- mem_rdata  in  32  read word.

Function
REQ-004 SHALL decode req_op as follows; every other code is illegal:
- 0000 LB, 0001 LBU, 0010 LH, 0011 LHU, 0100 LW, 0101 LWL, 0110 LWR.
- 1000 SB, 1001 SH, 1010 SW, 1011 SWL, 1100 SWR.
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA, RESP. req_ready = (state==IDLE).
REQ-006 SHALL register op, addr, wdata and rt_old on acceptance (req_valid & req_ready) and SHALL ignore req_* at all other times.
REQ-007 On acceptance, SHALL go IDLE->RESP with no memory access when either condition holds:
- illegal op: resp_err=11;
- misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0): resp_err=01.
Otherwise SHALL go IDLE->ADDR.
REQ-008 In ADDR, SHALL hold mem_req=1 with mem_addr, mem_wr, mem_wstrb and mem_wdata stable. On mem_addr_ok SHALL go ->DATA next cycle with mem_req=0.
REQ-009 In ADDR, SHALL count cycles. When TIMEOUT_CYC!=0 and the count reaches TIMEOUT_CYC without mem_addr_ok, SHALL drop mem_req and go ->RESP with resp_err=10. mem_addr_ok in the same cycle as timeout wins (goes ->DATA).
REQ-010 In DATA, SHALL wait without limit for mem_data_ok, then go ->RESP with resp_err=00 and resp_rdata computed from mem_rdata. Stores return resp_rdata=0.
REQ-011 In RESP, SHALL hold resp_valid=1 and the response stable until resp_ready, then go ->IDLE. Minimum request-to-request spacing is 1 idle cycle.
REQ-012 SHALL ignore mem_addr_ok/mem_data_ok in IDLE and RESP, and mem_data_ok in ADDR.
REQ-013 SHALL generate stores, with off = addr[1:0], as follows:
- SB: wdata = {4{b[7:0]}}, wstrb = 0001<<off.
- SH: wdata = {2{h[15:0]}}, wstrb = 0011 (off=0) or 1100 (off=2).
- SW: wstrb = 1111.
- SWL: wdata = wdata>>(8*(3-off)); wstrb for off 0..3 = 0001, 0011, 0111, 1111.
- SWR: wdata = wdata<<(8*off); wstrb for off 0..3 = 1111, 1110, 1100, 1000.
Loads SHALL use mem_wr=0 and mem_wstrb=0000.
REQ-014 SHALL form load results as follows:
- LB/LH: sign-extend the selected byte/halfword.
- LBU/LHU: zero-extend the selected byte/halfword.
- LW: mem_rdata.
- LWL, off 0..3: {rd[7:0],rt[23:0]}, {rd[15:0],rt[15:0]}, {rd[23:0],rt[7:0]}, rd.
- LWR, off 0..3: rd, {rt[31:24],rd[31:8]}, {rt[31:16],rd[31:16]}, {rt[31:8],rd[31:24]}.
REQ-015 SHALL register all outputs (no combinational path from resp_ready or mem_* inputs to any output).

Reset
REQ-016 reset=1 SHALL immediately force state=IDLE, timeout counter=0, and all outputs 0 except req_ready. req_ready SHALL be 1 from the first clock edge after deassertion.
REQ-017 Reset mid-transaction SHALL abandon it with no response. A mem_data_ok arriving after reset SHALL be ignored.

Verification
REQ-018 LB, addr=0x1003, mem_rdata=0x80FF_1234 -> mem_addr=0x1000, wstrb=0000, resp_rdata=0xFFFF_FF80, err=00.
REQ-019 SWL, addr=0x2001, wdata=0xAABB_CCDD -> wstrb=0011, mem_wdata[15:0]=0xAABB. SWR, same addr -> wstrb=1110, mem_wdata[31:8]=0xBBCCDD.
REQ-020 LWR, addr=0x12, rt_old=0x1122_3344, mem_rdata=0xA1B2_C3D4 -> resp_rdata=0x1122_A1B2.
REQ-021 LW, addr=0x6 -> no mem_req, resp_valid one cycle after acceptance, err=01. op=0111 -> err=11.
REQ-022 TIMEOUT_CYC=4, mem_addr_ok held 0 -> mem_req drops after 4 ADDR cycles, resp_err=10. resp_ready held 0 for 3 cycles -> resp stable, then IDLE.
REQ-023 Reset asserted in DATA, then a late mem_data_ok -> no resp_valid, req_ready=1 after reset release.
